uc_multiciclo: RTL and testbench

//  Multicycle control unit for the 64-bit datapath: PC, IR, registrador, memoria, Mux1, Mux2, adder.

---
 rtl/uc_multiciclo_pkg.sv | 39 +++
 rtl/uc_multiciclo.sv | 131 +++++++++++++
 tb/tb_uc_multiciclo.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uc_multiciclo_pkg.sv
// Shared definitions for the multicycle control unit.
//  - opcode values for the instruction set
//  - FSM state encoding
//  - select-table helper mapping an opcode to {sinal, sinalMux1, sinalMux2}
package uc_multiciclo_pkg;

  localparam int unsigned OP_HALT  = 0;
  localparam int unsigned OP_LOAD  = 1;
  localparam int unsigned OP_STORE = 2;
  localparam int unsigned OP_ADD   = 3;
  localparam int unsigned OP_SUB   = 4;
  localparam int unsigned OP_ADDI  = 5;
  localparam int unsigned OP_SUBI  = 6;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt,
    StErr
  } state_t;

  // Returns {sinal, sinalMux1, sinalMux2}. STORE ignores the writeback mux, so it is left at 0.
  function automatic logic [2:0] sel_for(int unsigned opc);
    logic [2:0] sel;
    case (opc)
      OP_ADD:  sel = 3'b011;
      OP_SUB:  sel = 3'b111;
      OP_ADDI: sel = 3'b001;
      OP_SUBI: sel = 3'b101;
      default: sel = 3'b000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uc_multiciclo.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback and drives the
// datapath enables and selects. Owns the PC and a retired-instruction counter.
// Ports:
//  clk, reset       clock (rising edge), asynchronous active-high reset
//  start            leaves IDLE; ignored in every other state
//  op               opcode from the IR, captured in DECODE
//  pc               current program counter
//  weIR/weReg/weMem IR load, register write, data-memory write enables
//  sinal            adder mode (0 add, 1 subtract)
//  sinalMux1        0 immediate, 1 Rb
//  sinalMux2        0 memory dout, 1 adder result
//  busy/halted/err  status flags (err is sticky until reset)
//  retired          completed-instruction count, wraps
module uc_multiciclo
  import uc_multiciclo_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned OP_W     = 4,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned PC_STEP  = 1,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] pc,
  output logic              weIR,
  output logic              weReg,
  output logic              weMem,
  output logic              sinal,
  output logic              sinalMux1,
  output logic              sinalMux2,
  output logic              busy,
  output logic              halted,
  output logic              err,
  output logic [CNT_W-1:0]  retired
);

  localparam int unsigned WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                retire;
  logic                is_load, is_store;

  assign is_load  = (32'(op_q) == OP_LOAD);
  assign is_store = (32'(op_q) == OP_STORE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= '0;
      wait_q    <= '0;
      pc_q      <= DATA_W'(RESET_PC);
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = wait_q;
    retire  = 1'b0;
    unique case (state_q)
      StIdle:   if (start) state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: begin
        op_d = op;
        if (32'(op) == OP_HALT)     state_d = StHalt;
        else if (32'(op) > OP_SUBI) state_d = StErr;
        else                        state_d = StExec;
      end
      StExec:   state_d = (is_load || is_store) ? StMem : StWb;
      StMem: begin
        if (is_store) begin
          retire  = 1'b1;
          state_d = StFetch;
        end else if (wait_q == WAIT_W'(MEM_LAT - 1)) begin
          // Read data is valid on the last wait cycle; writeback follows.
          wait_d  = '0;
          state_d = StWb;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWb: begin
        retire  = 1'b1;
        state_d = StFetch;
      end
      StHalt, StErr: state_d = state_q;
    endcase
    pc_d      = retire ? pc_q + DATA_W'(PC_STEP) : pc_q;
    retired_d = retire ? retired_q + 1'b1 : retired_q;
  end

  always_comb begin
    weIR      = 1'b0;
    weReg     = 1'b0;
    weMem     = 1'b0;
    sinal     = 1'b0;
    sinalMux1 = 1'b0;
    sinalMux2 = 1'b0;
    unique case (state_q)
      StFetch: weIR = 1'b1;
      StExec, StMem, StWb: begin
        {sinal, sinalMux1, sinalMux2} = sel_for(32'(op_q));
        weMem = (state_q == StMem) && is_store;
        weReg = (state_q == StWb);
      end
      default: ;
    endcase
    busy   = !(state_q inside {StIdle, StHalt, StErr});
    halted = (state_q == StHalt);
    err    = (state_q == StErr);
  end

  assign pc      = pc_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
module tb_uc_multiciclo;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned MEM_LAT = 3;
  localparam int unsigned PC_STEP = 1;
  localparam int unsigned CNT_W   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] pc;
  logic              weIR, weReg, weMem, sinal, sinalMux1, sinalMux2;
  logic              busy, halted, err;
  logic [CNT_W-1:0]  retired;

  uc_multiciclo #(
    .DATA_W  (DATA_W),
    .OP_W    (OP_W),
    .MEM_LAT (MEM_LAT),
    .PC_STEP (PC_STEP),
    .RESET_PC(0),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .pc       (pc),
    .weIR     (weIR),
    .weReg    (weReg),
    .weMem    (weMem),
    .sinal    (sinal),
    .sinalMux1(sinalMux1),
    .sinalMux2(sinalMux2),
    .busy     (busy),
    .halted   (halted),
    .err      (err),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  // Per-cycle expectation: {busy, weIR, weReg, weMem, sinal, sinalMux1, sinalMux2}, mask, pc.
  typedef struct packed {
    logic [6:0]  v;
    logic [6:0]  m;
    logic [63:0] pc;
  } exp_t;

  exp_t        q[$];
  int unsigned prog[16];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        exp_halt, exp_err;
  logic [63:0] exp_pc;
  int unsigned exp_ret;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {busy, weIR, weReg, weMem, sinal, sinalMux1, sinalMux2};
  endfunction

  task automatic push(input logic [6:0] v, input logic [6:0] m, input logic [63:0] p);
    exp_t e;
    e.v = v;
    e.m = m;
    e.pc = p;
    q.push_back(e);
  endtask

  // Reference sequencing model built straight from the opcode table and latencies.
  task automatic build_model();
    logic [63:0] pcm;
    int unsigned opc;
    logic [2:0]  s;
    pcm = '0;
    exp_ret = 0;
    exp_halt = 1'b0;
    exp_err = 1'b0;
    q.delete();
    for (int i = 0; i < 16; i++) begin
      opc = prog[i];
      push(7'b1100000, 7'h7f, pcm);
      push(7'b1000000, 7'h7f, pcm);
      if (opc == 0) begin
        exp_halt = 1'b1;
        break;
      end
      if (opc > 6) begin
        exp_err = 1'b1;
        break;
      end
      case (opc)
        3:       s = 3'b011;
        4:       s = 3'b111;
        5:       s = 3'b001;
        6:       s = 3'b101;
        default: s = 3'b000;
      endcase
      push({4'b1000, s}, 7'h7f, pcm);
      if (opc == 1) begin
        for (int k = 0; k < int'(MEM_LAT); k++) push({4'b1000, s}, 7'h7f, pcm);
        push({4'b1010, s}, 7'h7f, pcm);
      end else if (opc == 2) begin
        push({4'b1001, s}, 7'h7e, pcm);
      end else begin
        push({4'b1010, s}, 7'h7f, pcm);
      end
      pcm = pcm + 64'(PC_STEP);
      exp_ret++;
    end
    exp_pc = pcm;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs the loaded program for at most max_cyc cycles; full runs also check the end state.
  task automatic run_prog(input string name, input int max_cyc, input bit full);
    exp_t e;
    build_model();
    @(negedge clk);
    op = OP_W'(prog[0]);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= max_cyc && q.size() > 0; c++) begin
      @(negedge clk);
      op = OP_W'(prog[pc[3:0]]);
      e = q.pop_front();
      chk({name, " outs"}, 64'(outs() & e.m), 64'(e.v & e.m));
      chk({name, " pc"}, pc, e.pc);
    end
    if (full) begin
      @(negedge clk);
      chk({name, " pending"}, 64'(q.size()), 64'd0);
      chk({name, " halted"}, 64'(halted), 64'(exp_halt));
      chk({name, " err"}, 64'(err), 64'(exp_err));
      chk({name, " busy"}, 64'(busy), 64'd0);
      chk({name, " pc end"}, pc, exp_pc);
      chk({name, " retired"}, 64'(retired), 64'(exp_ret));
    end
  endtask

  // Holds start high in an absorbing state; nothing may move.
  task automatic idle_check(input string name, input int n);
    start = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk({name, " frozen outs"}, 64'(outs()), 64'd0);
      chk({name, " frozen flags"}, 64'({halted, err}), 64'({exp_halt, exp_err}));
      chk({name, " frozen pc"}, pc, exp_pc);
      chk({name, " frozen ret"}, 64'(retired), 64'(exp_ret));
    end
    start = 1'b0;
  endtask

  task automatic set_prog(input int unsigned p0, input int unsigned p1, input int unsigned p2,
                          input int unsigned p3, input int unsigned p4);
    for (int i = 0; i < 16; i++) prog[i] = 0;
    prog[0] = p0;
    prog[1] = p1;
    prog[2] = p2;
    prog[3] = p3;
    prog[4] = p4;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op = '0;
    #3;
    chk("reset outs", 64'(outs()), 64'd0);
    chk("reset flags", 64'({halted, err}), 64'd0);
    chk("reset pc", pc, 64'd0);
    chk("reset retired", 64'(retired), 64'd0);
    do_reset();

    // Reset while a LOAD sits in its memory wait (after one ADDI retired).
    set_prog(5, 1, 0, 0, 0);
    run_prog("ldrst", 9, 1'b0);
    chk("ldrst pre pc", pc, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("ldrst outs", 64'(outs()), 64'd0);
    chk("ldrst flags", 64'({halted, err}), 64'd0);
    chk("ldrst pc", pc, 64'd0);
    chk("ldrst retired", 64'(retired), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ldrst held outs", 64'(outs()), 64'd0);
    end
    reset = 1'b0;
    q.delete();

    set_prog(3, 0, 0, 0, 0);
    run_prog("add", 100, 1'b1);
    do_reset();

    set_prog(1, 0, 0, 0, 0);
    run_prog("load", 100, 1'b1);
    do_reset();

    set_prog(2, 2, 0, 0, 0);
    run_prog("store", 100, 1'b1);
    do_reset();

    set_prog(5, 6, 4, 2, 0);
    run_prog("prog", 100, 1'b1);
    idle_check("prog", 4);
    do_reset();

    set_prog(3, 9, 0, 0, 0);
    run_prog("illegal", 100, 1'b1);
    idle_check("illegal", 5);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
